// File: rtl/cobra_pkg.sv
// Shared definitions for the Cobra core and its program loader.
package cobra_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } ldr_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int IM_DEPTH       = 256;

    // Instruction field positions, shared with the core decoder.
    localparam int INSN_JMP_BIT    = 31;
    localparam int INSN_CJMP_BIT   = 30;
    localparam int INSN_WDSEL_HI   = 29;
    localparam int INSN_WDSEL_LO   = 28;
    localparam int INSN_ALUOP_HI   = 27;
    localparam int INSN_ALUOP_LO   = 23;
    localparam int INSN_RA1_HI     = 22;
    localparam int INSN_RA1_LO     = 18;
    localparam int INSN_RA2_HI     = 17;
    localparam int INSN_RA2_LO     = 13;
    localparam int INSN_IMM_HI     = 12;
    localparam int INSN_IMM_LO     = 5;
    localparam int INSN_WA_HI      = 4;
    localparam int INSN_WA_LO      = 0;

    // Running frame checksum: byte-wise XOR.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cobra_word_assembler.sv
// Collects four stream bytes, MSB first, into one 32-bit instruction word.
// word holds its value between completions; word_valid pulses one cycle
// after the byte that completes a word.
module cobra_word_assembler
    import cobra_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        lane_last,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane_r;
    logic [23:0] shift_r;
    logic [31:0] word_r;
    logic        word_valid_r;

    assign lane_last  = (lane_r == 2'(BYTES_PER_WORD - 1));
    assign word       = word_r;
    assign word_valid = word_valid_r;

    // Lane counter, shift register and completed-word capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lane_r       <= 2'd0;
            shift_r      <= 24'd0;
            word_r       <= 32'd0;
            word_valid_r <= 1'b0;
        end else if (clr) begin
            lane_r       <= 2'd0;
            shift_r      <= 24'd0;
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
            if (byte_valid) begin
                shift_r <= {shift_r[15:0], byte_in};
                lane_r  <= lane_r + 2'd1;
                if (lane_last) begin
                    word_r       <= {shift_r, byte_in};
                    word_valid_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cobra_prog_loader.sv
// Byte-serial loader for the Cobra instruction memory. Receives
// [count, words MSB first, XOR checksum], writes one word per four bytes
// and keeps the core in reset until a frame with a good checksum ends.
module cobra_prog_loader
    import cobra_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_wa,
    output logic [31:0]       im_wd,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    ldr_state_e        state_r, state_nxt_s;
    logic              hs_s, start_ok_s, expire_s, last_word_s, busy_nxt_s;
    logic              lane_last_s, asm_valid_s, asm_byte_s;
    logic [31:0]       asm_word_s;
    logic [7:0]        cnt_r, acc_r;
    logic [ADDR_W-1:0] widx_r, wa_r;
    logic [TMR_W-1:0]  tmr_r;
    logic              rx_ready_r, core_rst_r, busy_r, done_r, err_r;

    assign hs_s        = rx_valid & rx_ready_r;
    assign start_ok_s  = start & ((state_r == ST_IDLE) | (state_r == ST_ERR));
    // A handshake in the expiry cycle takes precedence over the timeout.
    assign expire_s    = (TIMEOUT != 0) & busy_r & ~hs_s & (tmr_r == TMR_W'(TIMEOUT - 1));
    assign last_word_s = ((ADDR_W+1)'(widx_r) + (ADDR_W+1)'(1'b1)) == (ADDR_W+1)'(cnt_r);
    assign asm_byte_s  = hs_s & (state_r == ST_DATA);
    assign busy_nxt_s  = (state_nxt_s == ST_LEN) | (state_nxt_s == ST_DATA) |
                         (state_nxt_s == ST_CSUM);

    cobra_word_assembler u_asm (
        .CLK        (CLK),
        .RST        (RST),
        .clr        (start_ok_s),
        .byte_valid (asm_byte_s),
        .byte_in    (rx_data),
        .lane_last  (lane_last_s),
        .word       (asm_word_s),
        .word_valid (asm_valid_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_LEN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_LEN: begin
                if (hs_s)          state_nxt_s = (rx_data == 8'd0) ? ST_CSUM : ST_DATA;
                else if (expire_s) state_nxt_s = ST_ERR;
                else               state_nxt_s = ST_LEN;
            end
            ST_DATA: begin
                if (hs_s && lane_last_s && last_word_s) state_nxt_s = ST_CSUM;
                else if (expire_s)                      state_nxt_s = ST_ERR;
                else                                    state_nxt_s = ST_DATA;
            end
            ST_CSUM: begin
                if (hs_s)          state_nxt_s = (rx_data == acc_r) ? ST_DONE : ST_ERR;
                else if (expire_s) state_nxt_s = ST_ERR;
                else               state_nxt_s = ST_CSUM;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_ERR: begin
                if (start) state_nxt_s = ST_LEN;
                else       state_nxt_s = ST_ERR;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Status outputs, registered from the next state so they track state_r.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            core_rst_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            rx_ready_r <= busy_nxt_s;
            busy_r     <= busy_nxt_s;
            core_rst_r <= busy_nxt_s | (state_nxt_s == ST_ERR);
            done_r     <= (state_nxt_s == ST_DONE);
            err_r      <= (state_nxt_s == ST_ERR);
        end
    end

    // Count, checksum accumulator, word index, write address and idle timer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r  <= 8'd0;
            acc_r  <= 8'd0;
            widx_r <= '0;
            wa_r   <= '0;
            tmr_r  <= '0;
        end else if (start_ok_s) begin
            acc_r  <= 8'd0;
            widx_r <= '0;
            tmr_r  <= '0;
        end else begin
            if (hs_s)        tmr_r <= '0;
            else if (busy_r) tmr_r <= tmr_r + TMR_W'(1);
            else             tmr_r <= tmr_r;

            if (hs_s && (state_r == ST_LEN)) begin
                cnt_r <= rx_data;
                acc_r <= rx_data;
            end else if (asm_byte_s) begin
                acc_r <= csum_update(acc_r, rx_data);
            end else begin
                acc_r <= acc_r;
            end

            if (asm_byte_s && lane_last_s) begin
                wa_r   <= widx_r;
                widx_r <= widx_r + ADDR_W'(1);
            end
        end
    end

    assign rx_ready = rx_ready_r;
    assign im_we    = asm_valid_s;
    assign im_wa    = wa_r;
    assign im_wd    = asm_word_s;
    assign core_rst = core_rst_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_cobra_prog_loader.sv
// Directed bench for cobra_prog_loader with a write scoreboard.
module tb_cobra_prog_loader;

    logic        CLK = 1'b0;
    logic        RST, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, im_we, core_rst, busy, done, err;
    logic [7:0]  im_wa;
    logic [31:0] im_wd;

    typedef struct packed {
        logic [7:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t        wr_q[$];
    wr_t        exp_w;
    logic [7:0] stream_q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_done = 0;
    int         exp_done = 0;

    cobra_prog_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .im_we(im_we), .im_wa(im_wa), .im_wd(im_wd),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every write strobe is matched against the scoreboard queue.
    always @(negedge CLK) begin
        if (im_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got wa=%0h wd=%h, none expected", im_wa, im_wd);
            end else begin
                exp_w = wr_q.pop_front();
                if (im_wa !== exp_w.wa || im_wd !== exp_w.wd) begin
                    errors++;
                    $display("FAIL write: got wa=%0h wd=%h expected wa=%0h wd=%h",
                             im_wa, im_wd, exp_w.wa, exp_w.wd);
                end
            end
        end
        if (done === 1'b1) n_done++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Present one byte and return at the negedge after its handshake.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte: rx_ready stayed 0 for byte %h", b);
        end else begin
            @(negedge CLK);
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input int gap, input bit mid_start);
        for (int i = 0; i < stream_q.size(); i++) begin
            send_byte(stream_q[i]);
            if (i != stream_q.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    start = (mid_start && i == 4 && g == 0) ? 1'b1 : 1'b0;
                    @(negedge CLK);
                end
                start = 1'b0;
            end
        end
    endtask

    task automatic load_case1(input logic [7:0] csum);
        stream_q = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        stream_q.push_back(csum);
        wr_q.push_back('{wa: 8'h00, wd: 32'h12345678});
        wr_q.push_back('{wa: 8'h01, wd: 32'hA0B0C0D0});
    endtask

    initial begin
        int cyc;
        RST = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {rx_ready, im_we, im_wa, im_wd, core_rst, busy, done, err}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // 1: good load
        load_case1(8'h0A);
        pulse_start();
        check("t1_core_rst_after_start", core_rst, 1);
        check("t1_rx_ready_in_len", rx_ready, 1);
        check("t1_busy", busy, 1);
        run_frame(0, 1'b0);
        exp_done++;
        check("t1_done_pulse", done, 1);
        check("t1_core_rst_released", core_rst, 0);
        @(negedge CLK);
        check("t1_done_one_cycle", done, 0);
        check("t1_idle_outs", {busy, rx_ready, core_rst, err}, 0);
        check("t1_writes_drained", wr_q.size(), 0);

        // 2: bad checksum
        load_case1(8'h0B);
        pulse_start();
        run_frame(0, 1'b0);
        check("t2_err", err, 1);
        check("t2_no_done", done, 0);
        repeat (3) @(negedge CLK);
        check("t2_hold", {err, core_rst, rx_ready, busy}, 4'b1100);
        check("t2_writes_drained", wr_q.size(), 0);

        // 3: empty program, started from ERR
        pulse_start();
        check("t3_err_cleared", err, 0);
        check("t3_core_rst", core_rst, 1);
        send_byte(8'h00);
        send_byte(8'h00);
        exp_done++;
        check("t3_done_two_after_count", done, 1);
        @(negedge CLK);
        check("t3_done_count", n_done, exp_done);

        // 4: throttled source with a stray start mid-load
        load_case1(8'h0A);
        pulse_start();
        run_frame(2, 1'b1);
        exp_done++;
        check("t4_done_pulse", done, 1);
        check("t4_err", err, 0);
        @(negedge CLK);
        check("t4_writes_drained", wr_q.size(), 0);
        check("t4_done_count", n_done, exp_done);

        // 5: timeout after two data bytes
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        cyc = 0;
        while (!err && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        check("t5_timeout_cycles", cyc, 16);
        check("t5_ready_dropped", {err, rx_ready, busy, core_rst}, 4'b1001);
        check("t5_no_writes", wr_q.size(), 0);

        // 6: reset in the middle of DATA
        pulse_start();
        wr_q.push_back('{wa: 8'h00, wd: 32'h12345678});
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("t6_reset_outputs", {rx_ready, im_we, im_wa, im_wd, core_rst, busy, done, err}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("t6_partial_write_seen", wr_q.size(), 0);
        load_case1(8'h0A);
        pulse_start();
        run_frame(0, 1'b0);
        exp_done++;
        check("t6_reload_done", done, 1);
        @(negedge CLK);
        check("t6_writes_drained", wr_q.size(), 0);
        check("final_done_count", n_done, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
